// File: rtl/game_session_ctrl_pkg.sv
// rtl/game_session_ctrl_pkg.sv - shared state codes and field widths for the game session sequencer
package game_pkg;

  localparam int DIFF_W = 2;
  localparam int BCD_W  = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAYING   = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_ROUND_END = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

endpackage

// File: rtl/game_session_ctrl_if.sv
// rtl/game_session_ctrl_if.sv - button/score inputs and display/enable outputs of the sequencer
// GAME_HISCORE_EN adds the hiscore output.
interface game_session_ctrl_if #(
  parameter int SCORE_W = 8
) ();
  import game_pkg::*;

  logic                tick_1hz;
  logic                btn_start;
  logic                btn_pause;
  logic                btn_diff;
  logic [DIFF_W-1:0]   diff_in;
  logic [SCORE_W-1:0]  score;
  logic [2:0]          state_o;
  logic                enable_score;
  logic                clear_score;
  logic                enable_mole_ctrl;
  logic [DIFF_W-1:0]   difficulty;
  logic [3:0]          round_num;
  logic [2*BCD_W-1:0]  disp_left;
  logic [SCORE_W-1:0]  disp_right;
`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0]  hiscore;
`endif

  modport master (
`ifdef GAME_HISCORE_EN
    input  hiscore,
`endif
    output tick_1hz, btn_start, btn_pause, btn_diff, diff_in, score,
    input  state_o, enable_score, clear_score, enable_mole_ctrl,
           difficulty, round_num, disp_left, disp_right
  );

  modport slave (
`ifdef GAME_HISCORE_EN
    output hiscore,
`endif
    input  tick_1hz, btn_start, btn_pause, btn_diff, diff_in, score,
    output state_o, enable_score, clear_score, enable_mole_ctrl,
           difficulty, round_num, disp_left, disp_right
  );

endinterface

// File: rtl/game_session_ctrl_bin2bcd_2dig.sv
// rtl/game_session_ctrl_bin2bcd_2dig.sv - 7-bit binary to two BCD digits, saturating at 99
module bin2bcd_2dig
  import game_pkg::*;
(
  input  logic [6:0]       bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [6:0] sat;

  always_comb begin
    sat  = (bin > 7'd99) ? 7'd99 : bin;
    tens = BCD_W'(sat / 7'd10);
    ones = BCD_W'(sat % 7'd10);
  end

endmodule

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - multi-round whack-a-mole session sequencer with pause and difficulty
// GAME_HISCORE_EN adds a session high-score register shown on disp_right in IDLE.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int CD_SEC     = 5,
  parameter int GAME_SEC   = 30,
  parameter int INTER_SEC  = 3,
  parameter int ROUNDS     = 3,
  parameter int NUM_LEVELS = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  game_session_ctrl_if.slave bus
);

  localparam logic [6:0]        CD_V     = 7'(CD_SEC);
  localparam logic [6:0]        GAME_V   = 7'(GAME_SEC);
  localparam logic [6:0]        INTER_V  = 7'(INTER_SEC);
  localparam logic [3:0]        ROUNDS_V = 4'(ROUNDS);
  localparam logic [DIFF_W-1:0] MAX_DIFF = DIFF_W'(NUM_LEVELS - 1);

  logic [2:0]         state;
  logic [6:0]         secs_left;
  logic [3:0]         round;
  logic [DIFF_W-1:0]  diff_r;
  logic               start_q;
  logic               last_sec;
  logic [BCD_W-1:0]   tens;
  logic [BCD_W-1:0]   ones;
  logic [SCORE_W-1:0] idle_val;

  assign last_sec = (secs_left == 7'd1);

  bin2bcd_2dig u_bcd (
    .bin  (secs_left),
    .tens (tens),
    .ones (ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      secs_left <= 7'd0;
      round     <= 4'd0;
      diff_r    <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q <= bus.btn_start;
      if (bus.btn_diff && (state == ST_IDLE || state == ST_GAME_OVER))
        diff_r <= (bus.diff_in > MAX_DIFF) ? MAX_DIFF : bus.diff_in;
      // Start overrides pause and tick from any state, including illegal codes
      if (bus.btn_start) begin
        state     <= ST_COUNTDOWN;
        round     <= 4'd1;
        secs_left <= CD_V;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_COUNTDOWN:
            if (bus.tick_1hz) begin
              if (last_sec) begin
                state     <= ST_PLAYING;
                secs_left <= GAME_V;
              end else
                secs_left <= secs_left - 7'd1;
            end
          ST_PLAYING:
            if (bus.btn_pause)
              state <= ST_PAUSED;
            else if (bus.tick_1hz) begin
              if (last_sec && round == ROUNDS_V) begin
                state     <= ST_GAME_OVER;
                secs_left <= 7'd0;
              end else if (last_sec) begin
                state     <= ST_ROUND_END;
                secs_left <= INTER_V;
              end else
                secs_left <= secs_left - 7'd1;
            end
          ST_PAUSED:
            if (bus.btn_pause)
              state <= ST_PLAYING;
          ST_ROUND_END:
            if (bus.tick_1hz) begin
              if (last_sec) begin
                state     <= ST_COUNTDOWN;
                round     <= round + 4'd1;
                secs_left <= CD_V;
              end else
                secs_left <= secs_left - 7'd1;
            end
          ST_GAME_OVER:
            secs_left <= 7'd0;
          default:
            state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef GAME_HISCORE_EN
  logic               go_over;
  logic [SCORE_W-1:0] hiscore_r;

  assign go_over = !bus.btn_start && state == ST_PLAYING && !bus.btn_pause &&
                   bus.tick_1hz && last_sec && round == ROUNDS_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hiscore_r <= '0;
    else if (go_over && bus.score > hiscore_r)
      hiscore_r <= bus.score;
  end

  assign bus.hiscore = hiscore_r;
  assign idle_val    = hiscore_r;
`else
  assign idle_val = SCORE_W'(diff_r);
`endif

  // Outputs trail the internal state by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.state_o          <= ST_IDLE;
      bus.enable_score     <= 1'b0;
      bus.enable_mole_ctrl <= 1'b0;
      bus.clear_score      <= 1'b0;
      bus.difficulty       <= '0;
      bus.round_num        <= 4'd0;
      bus.disp_left        <= '0;
      bus.disp_right       <= '0;
    end else begin
      bus.state_o          <= state;
      bus.enable_score     <= (state == ST_PLAYING);
      bus.enable_mole_ctrl <= (state == ST_PLAYING);
      bus.clear_score      <= start_q;
      bus.difficulty       <= diff_r;
      bus.round_num        <= round;
      bus.disp_left        <= {tens, ones};
      bus.disp_right       <= (state == ST_IDLE) ? idle_val : bus.score;
    end
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - table-driven scoreboard bench for game_session_ctrl
module tb_game_session_ctrl;
  import game_pkg::*;

  typedef struct {
    bit         sel;
    bit         start, pause, tick, diff;
    logic [1:0] din;
    bit         chk;
    logic [2:0] st;
    logic [7:0] dl;
    logic [3:0] rn;
    bit         en, clr;
    logic [1:0] dif;
    bit         dr_chk;
    logic [7:0] dr;
  } vec_t;

  typedef struct {
    int   due;
    int   chunk;
    int   idx;
    vec_t v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   chunk_id = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  game_session_ctrl_if #(.SCORE_W(8)) bus_a ();
  game_session_ctrl_if #(.SCORE_W(8)) bus_b ();

  game_session_ctrl #(.SCORE_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  game_session_ctrl #(.ROUNDS(2), .GAME_SEC(3), .INTER_SEC(2), .SCORE_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [7:0] idle_dr(input logic [7:0] dif, input logic [7:0] hs);
`ifdef GAME_HISCORE_EN
    return hs;
`else
    return dif;
`endif
  endfunction

  function automatic vec_t mk(input bit sel, input bit s, input bit p, input bit t, input bit d,
                              input logic [1:0] din, input logic [2:0] st, input logic [7:0] dl,
                              input logic [3:0] rn, input bit en, input bit clr, input logic [1:0] dif);
    vec_t v;
    v.sel = sel; v.start = s; v.pause = p; v.tick = t; v.diff = d; v.din = din;
    v.chk = 1'b1; v.st = st; v.dl = dl; v.rn = rn; v.en = en; v.clr = clr; v.dif = dif;
    v.dr_chk = 1'b0; v.dr = 8'h00;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    logic [2:0] st;
    logic [7:0] dl, dr;
    logic [3:0] rn;
    logic       es, em, clr;
    logic [1:0] dif;
    string      tag;
    if (e.v.sel) begin
      st = bus_b.state_o; dl = bus_b.disp_left; dr = bus_b.disp_right; rn = bus_b.round_num;
      es = bus_b.enable_score; em = bus_b.enable_mole_ctrl; clr = bus_b.clear_score; dif = bus_b.difficulty;
    end else begin
      st = bus_a.state_o; dl = bus_a.disp_left; dr = bus_a.disp_right; rn = bus_a.round_num;
      es = bus_a.enable_score; em = bus_a.enable_mole_ctrl; clr = bus_a.clear_score; dif = bus_a.difficulty;
    end
    tag = $sformatf("c%0d.row%0d", e.chunk, e.idx);
    check({tag, ".state"}, 32'(st), 32'(e.v.st));
    check({tag, ".disp_left"}, 32'(dl), 32'(e.v.dl));
    check({tag, ".round"}, 32'(rn), 32'(e.v.rn));
    check({tag, ".en_score"}, 32'(es), 32'(e.v.en));
    check({tag, ".en_mole"}, 32'(em), 32'(e.v.en));
    check({tag, ".clear"}, 32'(clr), 32'(e.v.clr));
    check({tag, ".difficulty"}, 32'(dif), 32'(e.v.dif));
    if (e.v.dr_chk)
      check({tag, ".disp_right"}, 32'(dr), 32'(e.v.dr));
  endtask

  task automatic cycle(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      compare(e);
    end
    bus_a.tick_1hz = !v.sel && v.tick;  bus_b.tick_1hz = v.sel && v.tick;
    bus_a.btn_start = !v.sel && v.start; bus_b.btn_start = v.sel && v.start;
    bus_a.btn_pause = !v.sel && v.pause; bus_b.btn_pause = v.sel && v.pause;
    bus_a.btn_diff = !v.sel && v.diff;  bus_b.btn_diff = v.sel && v.diff;
    bus_a.diff_in = v.din;              bus_b.diff_in = v.din;
    if (v.chk) begin
      e.due = cyc + 2; e.chunk = chunk_id; e.idx = idx; e.v = v;
      sb.push_back(e);
    end
  endtask

  task automatic run_tbl();
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 2'd0, 3'd0, 8'h00, 4'd0, 0, 0, 2'd0);
    idle.chk = 1'b0;
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i], i);
    for (int i = 0; i < 2; i++) cycle(idle, -1);
    check($sformatf("c%0d.drain", chunk_id), 32'(sb.size()), 32'd0);
    sb.delete();
    tbl.delete();
    chunk_id++;
  endtask

  task automatic add_ticks(input bit sel, input logic [2:0] st, input int from, input int to,
                           input logic [3:0] rn, input bit en, input logic [1:0] dif);
    for (int s = from; s >= to; s--) tbl.push_back(mk(sel, 0, 0, 1, 0, 2'd0, st, bcd(s), rn, en, 0, dif));
  endtask

  // DUT B: CD 5 s, 3 s play, 2 s inter-round pause, 2 rounds
  task automatic add_session_b(input logic [1:0] dif, input bit abort);
    tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0, ST_COUNTDOWN, bcd(5), 4'd1, 0, 1, dif));
    for (int r = 1; r <= 2; r++) begin
      add_ticks(1, ST_COUNTDOWN, 4, 1, 4'(r), 0, dif);
      tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_PLAYING, bcd(3), 4'(r), 1, 0, dif));
      if (abort && r == 2) begin
        tbl.push_back(mk(1, 1, 0, 1, 0, 2'd0, ST_COUNTDOWN, bcd(5), 4'd1, 0, 1, dif));
        return;
      end
      add_ticks(1, ST_PLAYING, 2, 1, 4'(r), 1, dif);
      if (r == 1) begin
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_ROUND_END, bcd(2), 4'd1, 0, 0, dif));
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_ROUND_END, bcd(1), 4'd1, 0, 0, dif));
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_COUNTDOWN, bcd(5), 4'd2, 0, 0, dif));
      end else
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_GAME_OVER, bcd(0), 4'd2, 0, 0, dif));
    end
  endtask

  initial begin
    bus_a.tick_1hz = 0; bus_a.btn_start = 0; bus_a.btn_pause = 0; bus_a.btn_diff = 0;
    bus_a.diff_in = 0;  bus_a.score = 8'h5A;
    bus_b.tick_1hz = 0; bus_b.btn_start = 0; bus_b.btn_pause = 0; bus_b.btn_diff = 0;
    bus_b.diff_in = 0;  bus_b.score = 8'd42;

    repeat (2) @(negedge clk);
    check("reset.state", 32'(bus_a.state_o), 32'(ST_IDLE));
    check("reset.disp_left", 32'(bus_a.disp_left), 32'h00);
    check("reset.disp_right", 32'(bus_a.disp_right), 32'h00);
    check("reset.enables", 32'({bus_a.enable_score, bus_a.enable_mole_ctrl, bus_a.clear_score}), 32'd0);
    check("reset.round", 32'(bus_b.round_num), 32'd0);
    rst_n = 1'b1;

    // Chunk 0: DUT A difficulty, countdown, pause/resume
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'd3, ST_IDLE, 8'h00, 4'd0, 0, 0, 2'd2));
    tbl[$].dr_chk = 1; tbl[$].dr = idle_dr(8'd2, 8'd0);
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'd1, ST_IDLE, 8'h00, 4'd0, 0, 0, 2'd1));
    tbl[$].dr_chk = 1; tbl[$].dr = idle_dr(8'd1, 8'd0);
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0, ST_COUNTDOWN, bcd(5), 4'd1, 0, 1, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, ST_COUNTDOWN, bcd(5), 4'd1, 0, 0, 2'd1));
    add_ticks(0, ST_COUNTDOWN, 4, 1, 4'd1, 0, 2'd1);
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd0, ST_PLAYING, bcd(30), 4'd1, 1, 0, 2'd1));
    add_ticks(0, ST_PLAYING, 29, 17, 4'd1, 1, 2'd1);
    tbl[$].dr_chk = 1; tbl[$].dr = 8'h5A;
    tbl.push_back(mk(0, 0, 1, 1, 0, 2'd0, ST_PAUSED, bcd(17), 4'd1, 0, 0, 2'd1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 0, 2'd0, ST_PAUSED, bcd(17), 4'd1, 0, 0, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2'd0, ST_PLAYING, bcd(17), 4'd1, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2'd0, ST_PLAYING, bcd(16), 4'd1, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'd3, ST_PLAYING, bcd(16), 4'd1, 1, 0, 2'd1));
    run_tbl();

    // Chunk 1: DUT B full session at score 42, then GAME_OVER hold behaviour
    add_session_b(2'd0, 1'b0);
    tbl.push_back(mk(1, 0, 0, 1, 0, 2'd0, ST_GAME_OVER, bcd(0), 4'd2, 0, 0, 2'd0));
    tbl[$].dr_chk = 1; tbl[$].dr = 8'd42;
    tbl.push_back(mk(1, 0, 1, 0, 0, 2'd0, ST_GAME_OVER, bcd(0), 4'd2, 0, 0, 2'd0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'd3, ST_GAME_OVER, bcd(0), 4'd2, 0, 0, 2'd2));
    run_tbl();
`ifdef GAME_HISCORE_EN
    check("hiscore.first", 32'(bus_b.hiscore), 32'd42);
`endif

    // Chunk 2: restart during round 2 with a same-cycle tick, then a full session at score 17
    bus_b.score = 8'd17;
    add_session_b(2'd2, 1'b1);
    add_session_b(2'd2, 1'b0);
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0, ST_GAME_OVER, bcd(0), 4'd2, 0, 0, 2'd2));
    tbl[$].dr_chk = 1; tbl[$].dr = 8'd17;
    run_tbl();
`ifdef GAME_HISCORE_EN
    check("hiscore.kept", 32'(bus_b.hiscore), 32'd42);
`endif

    // Asynchronous reset while DUT A is mid-round
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.state", 32'(bus_a.state_o), 32'(ST_IDLE));
    check("midreset.disp_left", 32'(bus_a.disp_left), 32'h00);
    check("midreset.round", 32'(bus_a.round_num), 32'd0);
    check("midreset.difficulty", 32'(bus_a.difficulty), 32'd0);
    check("midreset.enables", 32'({bus_a.enable_score, bus_a.enable_mole_ctrl}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postreset%0d.clear", i), 32'(bus_a.clear_score), 32'd0);
      check($sformatf("postreset%0d.state", i), 32'(bus_a.state_o), 32'(ST_IDLE));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
